// File: rtl/barrier_scheduler.sv
// rtl/barrier_scheduler.sv - lane sequencer, lives/score keeper and game-over flag for the barrier generator
//
// Picks a lane for each barrier from an 8-bit Galois LFSR, drives the generator's 2-bit active code,
// turns penguin-hit edges and barrier-done levels into lives/score updates, and raises game over when
// the last life is gone. All timing is in frames, counted on i_frame_tick while i_game_run is high.
//
// Optional feature macro: CFG_SPEEDUP_EN -- when defined, the gap between barriers shrinks by 4 frames
// after every 8th scored barrier, down to MIN_GAP_FRAMES. When undefined the gap stays at GAP_FRAMES.
//
// Ports:
//   i_clk          in   1   pixel clock
//   i_rst_n        in   1   asynchronous active-low reset
//   i_frame_tick   in   1   one-cycle pulse per frame
//   i_start        in   1   start pulse, honoured in IDLE or OVER while running
//   i_game_run     in   1   1 = run, 0 = pause (everything except the hit edge sampler freezes)
//   i_penguin_hit  in   1   collision level from the generator; its rising edge is a hit
//   i_barrier_done in   1   active barrier has scrolled off screen
//   o_active       out  2   00 none, 01 left, 10 mid, 11 right
//   o_lives        out  2   remaining lives
//   o_score        out  16  barriers cleared, saturating
//   o_game_over    out  1   high while in OVER

module barrier_scheduler #(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned GAP_FRAMES     = 60,
    parameter int unsigned MIN_GAP_FRAMES = 20,
    parameter int unsigned CLEAR_FRAMES   = 2,
    parameter int unsigned ACTIVE_TIMEOUT = 255,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_start,
    input  logic        i_game_run,
    input  logic        i_penguin_hit,
    input  logic        i_barrier_done,
    output logic [1:0]  o_active,
    output logic [1:0]  o_lives,
    output logic [15:0] o_score,
    output logic        o_game_over
);

    localparam logic [7:0] GAP_INIT     = 8'(GAP_FRAMES);
    localparam logic [7:0] CLEAR_LOAD   = 8'(CLEAR_FRAMES);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(ACTIVE_TIMEOUT);
    localparam logic [1:0] LIVES_LOAD   = 2'(LIVES_INIT);
    // Galois feedback mask for x^8+x^6+x^5+x^4+1 in the right-shifting form.
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_ACTIVE,
        S_CLEAR,
        S_OVER
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  lfsr, lfsr_n;
    logic [7:0]  lfsr_adv;
    logic [7:0]  gap, gap_n;
    logic [1:0]  lives, lives_n;
    logic [15:0] score, score_n;
    logic [15:0] score_inc;
    logic [1:0]  active, active_n;
    logic        hit_q;
    logic        hit_edge;
    logic        cnt_expiring;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Lane code 00 means "no barrier", so a zero draw is sent to the middle lane.
    function automatic logic [1:0] pick_lane(input logic [1:0] raw);
        pick_lane = (raw == 2'b00) ? 2'b10 : raw;
    endfunction

`ifdef CFG_SPEEDUP_EN
    localparam logic [7:0] GAP_FLOOR = 8'(MIN_GAP_FRAMES);

    function automatic logic [7:0] shrink_gap(input logic [7:0] g);
        shrink_gap = ({1'b0, g} >= ({1'b0, GAP_FLOOR} + 9'd4)) ? (g - 8'd4) : GAP_FLOOR;
    endfunction
`else
    logic [7:0] unused_min_gap;
    assign unused_min_gap = 8'(MIN_GAP_FRAMES);
`endif

    // The hit sampler runs even while paused so an edge seen during pause is not replayed later.
    assign hit_edge     = i_penguin_hit & ~hit_q;
    // The counter holds the frames still to go; the tick that takes it to zero is the transition tick.
    assign cnt_expiring = (cnt <= 8'd1);
    assign score_inc    = score + 16'd1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lfsr_n   = lfsr;
        gap_n    = gap;
        lives_n  = lives;
        score_n  = score;
        active_n = active;
        lfsr_adv = lfsr_step(lfsr);

        if (i_game_run) begin
            case (state)
                S_IDLE, S_OVER: begin
                    if (i_start) begin
                        state_n  = S_GAP;
                        lives_n  = LIVES_LOAD;
                        score_n  = 16'd0;
                        gap_n    = GAP_INIT;
                        cnt_n    = GAP_INIT;
                        active_n = 2'b00;
                    end
                end

                S_GAP: begin
                    if (i_frame_tick) begin
                        lfsr_n = lfsr_adv;
                        if (cnt_expiring) begin
                            // Lane is drawn from the value the LFSR steps to on the expiring tick.
                            state_n  = S_ACTIVE;
                            cnt_n    = TIMEOUT_LOAD;
                            active_n = pick_lane(lfsr_adv[1:0]);
                        end else begin
                            cnt_n = cnt - 8'd1;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (hit_edge) begin
                        // A hit outranks a simultaneous done: the barrier was not cleared.
                        if (lives != 2'd0) begin
                            lives_n = lives - 2'd1;
                        end
                        state_n  = S_CLEAR;
                        cnt_n    = CLEAR_LOAD;
                        active_n = 2'b00;
                    end else if (i_barrier_done) begin
                        if (score != 16'hFFFF) begin
                            score_n = score_inc;
`ifdef CFG_SPEEDUP_EN
                            if (score_inc[2:0] == 3'd0) begin
                                gap_n = shrink_gap(gap);
                            end
`endif
                        end
                        state_n  = S_CLEAR;
                        cnt_n    = CLEAR_LOAD;
                        active_n = 2'b00;
                    end else if (i_frame_tick) begin
                        if (cnt_expiring) begin
                            state_n  = S_CLEAR;
                            cnt_n    = CLEAR_LOAD;
                            active_n = 2'b00;
                        end else begin
                            cnt_n = cnt - 8'd1;
                        end
                    end
                end

                S_CLEAR: begin
                    // Holding 00 here lets the generator drop its hit latch before the next barrier.
                    if (i_frame_tick) begin
                        if (cnt_expiring) begin
                            if (lives == 2'd0) begin
                                state_n = S_OVER;
                                cnt_n   = 8'd0;
                            end else begin
                                state_n = S_GAP;
                                cnt_n   = gap;
                            end
                        end else begin
                            cnt_n = cnt - 8'd1;
                        end
                    end
                end

                default: begin
                    state_n  = S_IDLE;
                    cnt_n    = 8'd0;
                    active_n = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            lfsr   <= LFSR_SEED;
            gap    <= GAP_INIT;
            lives  <= 2'd0;
            score  <= 16'd0;
            active <= 2'b00;
            hit_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lfsr   <= lfsr_n;
            gap    <= gap_n;
            lives  <= lives_n;
            score  <= score_n;
            active <= active_n;
            hit_q  <= i_penguin_hit;
        end
    end

    assign o_active    = active;
    assign o_lives     = lives;
    assign o_score     = score;
    assign o_game_over = (state == S_OVER);

endmodule
